// File: rtl/ami_r_if.sv
// Bus bundle for the AXI read master: AR/R channels toward the slave and the
// command/data handshake toward user logic. The master modport is the view of
// ami_r; the slave modport is the view of whatever sits on the other side.
interface ami_r_if #(
    parameter int AXI_DW     = 128,
    parameter int AXI_AW     = 40,
    parameter int AXI_IW     = 8,
    parameter int AXI_LW     = 8,
    parameter int AXI_SW     = 3,
    parameter int AXI_BURSTW = 2,
    parameter int AXI_RRESPW = 2
);
    // AR channel
    logic [AXI_IW-1:0]     ARID;
    logic [AXI_AW-1:0]     ARADDR;
    logic [AXI_LW-1:0]     ARLEN;
    logic [AXI_SW-1:0]     ARSIZE;
    logic [AXI_BURSTW-1:0] ARBURST;
    logic                  ARVALID;
    logic                  ARREADY;
    // R channel
    logic [AXI_IW-1:0]     RID;
    logic [AXI_DW-1:0]     RDATA;
    logic [AXI_RRESPW-1:0] RRESP;
    logic                  RLAST;
    logic                  RVALID;
    logic                  RREADY;
    // user command
    logic [AXI_IW-1:0]     u_arid;
    logic [AXI_AW-1:0]     u_araddr;
    logic [AXI_LW-1:0]     u_arlen;
    logic [AXI_SW-1:0]     u_arsize;
    logic [AXI_BURSTW-1:0] u_arburst;
    logic                  u_arvalid;
    logic                  u_arready;
    // user read data
    logic [AXI_IW-1:0]     u_rid;
    logic [AXI_DW-1:0]     u_rdata;
    logic [AXI_RRESPW-1:0] u_rresp;
    logic                  u_rlast;
    logic                  u_rvalid;
    logic                  u_rready;

    modport master (
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY,
        input  u_arid, u_araddr, u_arlen, u_arsize, u_arburst, u_arvalid,
        output u_arready,
        output u_rid, u_rdata, u_rresp, u_rlast, u_rvalid,
        input  u_rready
    );

    modport slave (
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY,
        output u_arid, u_araddr, u_arlen, u_arsize, u_arburst, u_arvalid,
        input  u_arready,
        input  u_rid, u_rdata, u_rresp, u_rlast, u_rvalid,
        output u_rready
    );
endinterface

// File: rtl/ami_r.sv
// AXI read master. User commands are screened (burst type, size, 4KB crossing),
// issued on AR with one cycle of latency, and tracked in order. R beats are
// counted against the oldest outstanding burst, checked for ID/LAST agreement
// and buffered for user logic together with the counter-derived last flag.
module ami_r #(
    parameter int AXI_DW     = 128,
    parameter int AXI_AW     = 40,
    parameter int AXI_IW     = 8,
    parameter int AXI_LW     = 8,
    parameter int AXI_SW     = 3,
    parameter int AXI_BURSTW = 2,
    parameter int AXI_RRESPW = 2,
    parameter int MST_OD     = 4,
    parameter int MST_RD     = 16
) (
    input  logic                         ACLK,
    input  logic                         ARESETn,
    ami_r_if.master                      bus,
    output logic [$clog2(MST_OD+1)-1:0]  od_cnt,
    output logic                         error_cmd,
    output logic                         error_rid,
    output logic                         error_rlast
);
    localparam int CW  = $clog2(MST_OD + 1);
    localparam int OAW = $clog2(MST_OD);
    localparam int RAW = $clog2(MST_RD);
    localparam int RPW = RAW + 1;
    localparam int RBW = AXI_IW + AXI_DW + AXI_RRESPW + 1;
    localparam logic [AXI_SW-1:0]     SIZE_MAX   = AXI_SW'($clog2(AXI_DW / 8));
    localparam logic [AXI_BURSTW-1:0] BURST_INCR = AXI_BURSTW'(1);
    localparam logic [AXI_BURSTW-1:0] BURST_WRAP = AXI_BURSTW'(2);

    // WRAP/reserved bursts, oversize beats and INCR bursts leaving their 4KB
    // page are refused. A burst spans at most 4KB, so comparing page numbers
    // is the same as comparing bit 12 of first and last byte address.
    function automatic logic cmd_reject(
        input logic [AXI_AW-1:0]     addr,
        input logic [AXI_LW-1:0]     len,
        input logic [AXI_SW-1:0]     size,
        input logic [AXI_BURSTW-1:0] burst
    );
        logic [AXI_AW:0] aligned;
        logic [AXI_AW:0] nbytes;
        logic [AXI_AW:0] last_byte;
        aligned   = {1'b0, addr} & ({(AXI_AW+1){1'b1}} << size);
        nbytes    = ({{(AXI_AW+1-AXI_LW){1'b0}}, len} + {{AXI_AW{1'b0}}, 1'b1}) << size;
        last_byte = aligned + nbytes - {{AXI_AW{1'b0}}, 1'b1};
        if (burst >= BURST_WRAP) begin
            cmd_reject = 1'b1;
        end else if (size > SIZE_MAX) begin
            cmd_reject = 1'b1;
        end else if ((burst == BURST_INCR) && (last_byte[AXI_AW:12] != {1'b0, addr[AXI_AW-1:12]})) begin
            cmd_reject = 1'b1;
        end else begin
            cmd_reject = 1'b0;
        end
    endfunction

    logic                  arvalid_q;
    logic [AXI_IW-1:0]     arid_q;
    logic [AXI_AW-1:0]     araddr_q;
    logic [AXI_LW-1:0]     arlen_q;
    logic [AXI_SW-1:0]     arsize_q;
    logic [AXI_BURSTW-1:0] arburst_q;
    logic [CW-1:0]         od_cnt_q, od_cnt_d;
    logic [OAW-1:0]        trk_wr_q, trk_rd_q;
    logic [AXI_IW-1:0]     trk_id_q  [MST_OD];
    logic [AXI_LW-1:0]     trk_len_q [MST_OD];
    logic [AXI_LW-1:0]     beat_cnt_q;
    logic [RPW-1:0]        rb_wr_q, rb_rd_q;
    logic [RBW-1:0]        rb_mem_q [MST_RD];
    logic                  err_cmd_q, err_rid_q, err_rlast_q;

    logic u_arready_s, accept_s, reject_s, push_s, pop_s;
    logic trk_empty_s, exp_last_s, r_hs_s, r_known_s;
    logic rb_full_s, rb_empty_s, rb_rd_s;
    logic [AXI_IW-1:0] head_id_s;
    logic [AXI_LW-1:0] head_len_s;

    // Handshake decode, tracking head lookup and outstanding-count next state
    always_comb begin
        u_arready_s = (~arvalid_q | bus.ARREADY) & (od_cnt_q < CW'(MST_OD));
        accept_s    = bus.u_arvalid & u_arready_s;
        reject_s    = cmd_reject(bus.u_araddr, bus.u_arlen, bus.u_arsize, bus.u_arburst);
        push_s      = accept_s & ~reject_s;
        trk_empty_s = (od_cnt_q == {CW{1'b0}});
        head_id_s   = trk_id_q[trk_rd_q];
        head_len_s  = trk_len_q[trk_rd_q];
        exp_last_s  = (beat_cnt_q == head_len_s);
        rb_empty_s  = (rb_wr_q == rb_rd_q);
        rb_full_s   = (rb_wr_q[RAW] != rb_rd_q[RAW]) && (rb_wr_q[RAW-1:0] == rb_rd_q[RAW-1:0]);
        r_hs_s      = bus.RVALID & ~rb_full_s;
        r_known_s   = r_hs_s & ~trk_empty_s;
        pop_s       = r_known_s & exp_last_s;
        rb_rd_s     = ~rb_empty_s & bus.u_rready;
        if (push_s && !pop_s) begin
            od_cnt_d = od_cnt_q + CW'(1);
        end else if (!push_s && pop_s) begin
            od_cnt_d = od_cnt_q - CW'(1);
        end else begin
            od_cnt_d = od_cnt_q;
        end
    end

    // AR register: load on an accepted command, release after the handshake
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            arvalid_q <= 1'b0;
            arid_q    <= {AXI_IW{1'b0}};
            araddr_q  <= {AXI_AW{1'b0}};
            arlen_q   <= {AXI_LW{1'b0}};
            arsize_q  <= {AXI_SW{1'b0}};
            arburst_q <= {AXI_BURSTW{1'b0}};
        end else if (push_s) begin
            arvalid_q <= 1'b1;
            arid_q    <= bus.u_arid;
            araddr_q  <= bus.u_araddr;
            arlen_q   <= bus.u_arlen;
            arsize_q  <= bus.u_arsize;
            arburst_q <= bus.u_arburst;
        end else if (bus.ARREADY) begin
            arvalid_q <= 1'b0;
        end
    end

    // Tracking pointers, outstanding count and beat position within the head burst
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            trk_wr_q   <= {OAW{1'b0}};
            trk_rd_q   <= {OAW{1'b0}};
            od_cnt_q   <= {CW{1'b0}};
            beat_cnt_q <= {AXI_LW{1'b0}};
        end else begin
            od_cnt_q <= od_cnt_d;
            if (push_s) begin
                trk_wr_q <= trk_wr_q + OAW'(1);
            end
            if (pop_s) begin
                trk_rd_q   <= trk_rd_q + OAW'(1);
                beat_cnt_q <= {AXI_LW{1'b0}};
            end else if (r_known_s) begin
                beat_cnt_q <= beat_cnt_q + AXI_LW'(1);
            end
        end
    end

    // Tracking storage: {id, len} of each issued burst in order
    always_ff @(posedge ACLK) begin
        if (push_s) begin
            trk_id_q[trk_wr_q]  <= bus.u_arid;
            trk_len_q[trk_wr_q] <= bus.u_arlen;
        end
    end

    // R buffer pointers; beats with no outstanding burst are dropped
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rb_wr_q <= {RPW{1'b0}};
            rb_rd_q <= {RPW{1'b0}};
        end else begin
            if (r_known_s) begin
                rb_wr_q <= rb_wr_q + RPW'(1);
            end
            if (rb_rd_s) begin
                rb_rd_q <= rb_rd_q + RPW'(1);
            end
        end
    end

    // R buffer storage: {RID, RDATA, RRESP, expected last}
    always_ff @(posedge ACLK) begin
        if (r_known_s) begin
            rb_mem_q[rb_wr_q[RAW-1:0]] <= {bus.RID, bus.RDATA, bus.RRESP, exp_last_s};
        end
    end

    // Error pulses, one cycle after the offending command or beat
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            err_cmd_q   <= 1'b0;
            err_rid_q   <= 1'b0;
            err_rlast_q <= 1'b0;
        end else begin
            err_cmd_q   <= accept_s & reject_s;
            err_rid_q   <= r_hs_s & (trk_empty_s | (bus.RID != head_id_s));
            err_rlast_q <= r_known_s & (bus.RLAST != exp_last_s);
        end
    end

    assign bus.ARVALID   = arvalid_q;
    assign bus.ARID      = arid_q;
    assign bus.ARADDR    = araddr_q;
    assign bus.ARLEN     = arlen_q;
    assign bus.ARSIZE    = arsize_q;
    assign bus.ARBURST   = arburst_q;
    assign bus.RREADY    = ~rb_full_s;
    assign bus.u_arready = u_arready_s;
    assign bus.u_rvalid  = ~rb_empty_s;
    assign {bus.u_rid, bus.u_rdata, bus.u_rresp, bus.u_rlast} = rb_mem_q[rb_rd_q[RAW-1:0]];
    assign od_cnt        = od_cnt_q;
    assign error_cmd     = err_cmd_q;
    assign error_rid     = err_rid_q;
    assign error_rlast   = err_rlast_q;
endmodule
